// File: rtl/csi_rx_cal_pkg.sv
// Shared types and helpers for the CSI-2 RX input-delay calibration block.
package csi_rx_cal_pkg;

    localparam int unsigned TAP_W = 5;
    localparam int unsigned NTAPS = 32;
    // Window lengths reach 32, so one extra bit over the tap index.
    localparam int unsigned WIN_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SCORE,
        ST_NEXT,
        ST_COMMIT
    } cal_state_e;

    // True when data equals any of the 8 bit-rotations of pat.
    function automatic logic is_rot(input logic [7:0] data, input logic [7:0] pat);
        logic       hit;
        logic [7:0] rot;
        hit = 1'b0;
        rot = pat;
        for (int r = 0; r < 8; r++) begin
            if (data == rot) hit = 1'b1;
            rot = {rot[6:0], rot[7]};
        end
        return hit;
    endfunction

endpackage

// File: rtl/csi_rx_dly_cal_if.sv
// Control/status and data bundle between the RX top, the PHY lanes and the
// delay calibration controller.
interface csi_rx_dly_cal_if
    import csi_rx_cal_pkg::*;
#(
    parameter int unsigned NLANES = 2
) ();

    logic                      cal_start;
    logic [8*NLANES-1:0]       deser_in;
    logic [TAP_W*NLANES-1:0]   delay;
    logic                      cal_busy;
    logic                      cal_done;
    logic [NLANES-1:0]         cal_err;

    // Calibration controller side.
    modport master (
        input  cal_start,
        input  deser_in,
        output delay,
        output cal_busy,
        output cal_done,
        output cal_err
    );

    // RX top / PHY side.
    modport slave (
        output cal_start,
        output deser_in,
        input  delay,
        input  cal_busy,
        input  cal_done,
        input  cal_err
    );

endinterface

// File: rtl/csi_rx_cal_eye.sv
// Tracks contiguous good-tap runs during a sweep and keeps the widest one.
// Ties keep the earlier window; no wrap-around from tap 31 to tap 0.
module csi_rx_cal_eye
    import csi_rx_cal_pkg::*;
(
    input  logic             byte_clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             upd,
    input  logic             good,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [WIN_W-1:0] best_len
);

    logic [WIN_W-1:0] run_len_q;
    logic [TAP_W-1:0] run_start_q;
    logic [WIN_W-1:0] run_len_c;
    logic [TAP_W-1:0] run_start_c;

    // Candidate run after accepting the current tap as good.
    always_comb begin
        run_len_c   = run_len_q + WIN_W'(1);
        run_start_c = (run_len_q == '0) ? tap : run_start_q;
    end

    // Run and best-window registers.
    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            run_len_q   <= '0;
            run_start_q <= '0;
            best_len    <= '0;
            best_start  <= '0;
        end else if (clear) begin
            run_len_q   <= '0;
            run_start_q <= '0;
            best_len    <= '0;
            best_start  <= '0;
        end else if (upd) begin
            if (good) begin
                run_len_q   <= run_len_c;
                run_start_q <= run_start_c;
                if (run_len_c > best_len) begin
                    best_len   <= run_len_c;
                    best_start <= run_start_c;
                end
            end else begin
                run_len_q <= '0;
            end
        end
    end

endmodule

// File: rtl/csi_rx_dly_cal.sv
// CSI-2 RX HS lane IDELAY calibration: sweeps all 32 taps per lane, scores
// each against a rotated training byte and commits the widest eye centre.
// Optional feature macro: CSI_RX_DLY_CAL_RESCAN_EN (periodic automatic
// recalibration; a failing rescan keeps the last passing delay).
module csi_rx_dly_cal
    import csi_rx_cal_pkg::*;
#(
    parameter int unsigned      NLANES      = 2,
    parameter logic [TAP_W-1:0] DEFAULT_TAP = 5'd3,
    parameter logic [7:0]       TRAIN_BYTE  = 8'hB8,
    parameter int unsigned      SETTLE      = 16,
    parameter int unsigned      DWELL       = 64,
    parameter int unsigned      MIN_EYE     = 4
`ifdef CSI_RX_DLY_CAL_RESCAN_EN
    ,
    parameter int unsigned      RESCAN_CYCLES = 2**24
`endif
) (
    input  logic             byte_clock,
    input  logic             reset_n,
    csi_rx_dly_cal_if.master bus
);

    localparam int unsigned LANE_W = 2;
    localparam int unsigned CNT_W  = 16;

    cal_state_e                   state_q, state_d;
    logic [LANE_W-1:0]            lane_q, lane_d;
    logic [TAP_W-1:0]             tap_q, tap_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [7:0]                   ref_q, ref_d;
    logic                         ok_q, ok_d;
    logic [NLANES-1:0][TAP_W-1:0] delay_q, delay_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [NLANES-1:0]            err_q, err_d;

    logic [7:0]                   lane_byte_c;
    logic                         go_c;
    logic                         eye_clr_c;
    logic                         eye_upd_c;
    logic                         pass_c;
    logic [WIN_W-1:0]             centre_c;
    logic [TAP_W-1:0]             fail_tap_c;
    logic [TAP_W-1:0]             best_start;
    logic [WIN_W-1:0]             best_len;

    // Deserialised byte of the lane under calibration.
    always_comb begin
        lane_byte_c = 8'h00;
        for (int i = 0; i < NLANES; i++) begin
            if (lane_q == LANE_W'(i)) lane_byte_c = bus.deser_in[8*i +: 8];
        end
    end

    // Eye result for the lane just swept.
    always_comb begin
        pass_c   = best_len >= WIN_W'(MIN_EYE);
        centre_c = WIN_W'(best_start) + (best_len >> 1);
    end

`ifdef CSI_RX_DLY_CAL_RESCAN_EN
    localparam int unsigned RS_W = $clog2(RESCAN_CYCLES + 1);

    logic [RS_W-1:0]              rs_cnt_q;
    logic                         rescan_c;
    logic                         rescan_q;
    logic [NLANES-1:0][TAP_W-1:0] keep_q;
    logic [NLANES-1:0]            keep_vld_q;

    assign rescan_c = (state_q == ST_IDLE) && done_q &&
                      (rs_cnt_q == RS_W'(RESCAN_CYCLES - 1));
    assign go_c     = bus.cal_start || rescan_c;

    // Idle interval counter, running only while idle after a finished sweep.
    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            rs_cnt_q <= '0;
        end else if ((state_q != ST_IDLE) || !done_q || rescan_c) begin
            rs_cnt_q <= '0;
        end else begin
            rs_cnt_q <= rs_cnt_q + RS_W'(1);
        end
    end

    // Sweep origin and last passing delay per lane.
    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            rescan_q   <= 1'b0;
            keep_q     <= '0;
            keep_vld_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && go_c) rescan_q <= !bus.cal_start;
            if ((state_q == ST_COMMIT) && pass_c) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (lane_q == LANE_W'(i)) begin
                        keep_q[i]     <= TAP_W'(centre_c);
                        keep_vld_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // A failing rescan falls back to the lane's last passing delay.
    always_comb begin
        fail_tap_c = DEFAULT_TAP;
        for (int i = 0; i < NLANES; i++) begin
            if ((lane_q == LANE_W'(i)) && rescan_q && keep_vld_q[i]) fail_tap_c = keep_q[i];
        end
    end
`else
    assign go_c       = bus.cal_start;
    assign fail_tap_c = DEFAULT_TAP;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        tap_d     = tap_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        ok_d      = ok_q;
        delay_d   = delay_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        eye_clr_c = 1'b0;
        eye_upd_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go_c) begin
                    state_d   = ST_LOAD;
                    lane_d    = '0;
                    tap_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = '0;
                    eye_clr_c = 1'b1;
                end
            end
            ST_LOAD: begin
                for (int i = 0; i < NLANES; i++) begin
                    if (lane_q == LANE_W'(i)) delay_d[i] = tap_q;
                end
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SCORE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SCORE: begin
                if (cnt_q == '0) begin
                    ref_d = lane_byte_c;
                    ok_d  = is_rot(lane_byte_c, TRAIN_BYTE);
                end else begin
                    ok_d = ok_q && (lane_byte_c == ref_q);
                end
                if (cnt_q == CNT_W'(DWELL - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_NEXT: begin
                eye_upd_c = 1'b1;
                if (tap_q == TAP_W'(NTAPS - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    tap_d   = tap_q + TAP_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                for (int i = 0; i < NLANES; i++) begin
                    if (lane_q == LANE_W'(i)) begin
                        if (pass_c) begin
                            delay_d[i] = TAP_W'(centre_c);
                        end else begin
                            delay_d[i] = fail_tap_c;
                            err_d[i]   = 1'b1;
                        end
                    end
                end
                if (lane_q == LANE_W'(NLANES - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    lane_d    = lane_q + LANE_W'(1);
                    tap_d     = '0;
                    eye_clr_c = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Datapath and status registers.
    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            lane_q  <= '0;
            tap_q   <= '0;
            cnt_q   <= '0;
            ref_q   <= '0;
            ok_q    <= 1'b0;
            delay_q <= {NLANES{DEFAULT_TAP}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            lane_q  <= lane_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            ok_q    <= ok_d;
            delay_q <= delay_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Single window tracker shared by all lanes; cleared between lanes.
    csi_rx_cal_eye u_eye (
        .byte_clock (byte_clock),
        .reset_n    (reset_n),
        .clear      (eye_clr_c),
        .upd        (eye_upd_c),
        .good       (ok_q),
        .tap        (tap_q),
        .best_start (best_start),
        .best_len   (best_len)
    );

    assign bus.delay    = delay_q;
    assign bus.cal_busy = busy_q;
    assign bus.cal_done = done_q;
    assign bus.cal_err  = err_q;

endmodule

// File: doc/csi_rx_dly_cal.md
# csi_rx_dly_cal

Input-delay calibration controller for the CSI-2 RX HS data lanes. Sequentially sweeps the 5-bit IDELAY tap of each lane over all 32 positions and scores each tap against a repeating training byte seen at the ISERDES output. It then finds the widest contiguous good-tap window and programs the lane's delay to the window centre. It sits between the RX top and the per-lane PHY data instances, driving their `delay` inputs and observing their `deser_out`.

## Interface
- `NLANES`, 2: number of data lanes calibrated, 1..4.
- `DEFAULT_TAP`, 5'd3: tap driven after reset, and for any lane whose calibration fails.
- `TRAIN_BYTE`, 8'hB8: training byte; any of its 8 bit-rotations is accepted.
- `SETTLE`, 16: byte-clock cycles waited after a tap change before scoring starts.
- `DWELL`, 64: byte-clock cycles scored per tap.
- `MIN_EYE`, 4: minimum good-window length for a pass.
- `RESCAN_CYCLES`, 2**24: idle interval between automatic recalibrations. Used only with the macro.

Ports:
- `byte_clock`, in, 1: sole clock, ISERDES CLKDIV domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cal_start`, in, 1: single-cycle start request.
- `deser_in`, in, 8*NLANES: `deser_out` of each lane; lane i occupies [8i+7:8i].
- `delay`, out, 5*NLANES: tap for each lane; lane i occupies [5i+4:5i].
- `cal_busy`, out, 1: sweep in progress.
- `cal_done`, out, 1: sticky; set when all lanes have finished, cleared on the next accepted start.
- `cal_err`, out, NLANES: sticky per-lane fail flag, cleared on the next accepted start.

## Operation
- FSM states: IDLE, LOAD, SETTLE, SCORE, NEXT, COMMIT.
- IDLE -> LOAD when `cal_start` is 1 (or on rescan, see Configuration).
  - On entry: lane index = 0, tap = 0, best_len = 0, run_len = 0.
  - `cal_done` and `cal_err` clear.
  - `cal_start` is ignored while `cal_busy` is 1.
- LOAD: drive the selected lane's `delay` with the current tap. Go to SETTLE. Other lanes keep their last committed value.
- SETTLE: count SETTLE cycles, then go to SCORE.
- SCORE: over DWELL cycles, capture the first byte of the lane as `ref`.
  - The tap is good iff `ref` is a rotation of TRAIN_BYTE and every subsequent byte equals `ref`.
  - The good/bad decision is registered on the last SCORE cycle.
- NEXT: update the window tracker.
  - Good tap: run_len += 1; run_start is latched at the first good tap of a run.
  - If run_len > best_len (strictly greater), best := run. Ties keep the earlier window.
  - Bad tap: run_len = 0.
  - Taps 31 and 0 are not contiguous; there is no wrap-around.
  - If tap < 31: tap += 1 and go to LOAD. Otherwise go to COMMIT.
- COMMIT:
  - Pass (best_len >= MIN_EYE): lane delay = best_start + (best_len >> 1), floor, 5-bit. The result never exceeds 31.
  - Fail: delay = DEFAULT_TAP and `cal_err[lane]` is set.
  - If more lanes remain: lane += 1 and go to LOAD.
  - Otherwise: `cal_done` = 1, `cal_busy` = 0, go to IDLE.
- Window counters are 6 bits wide, so a run length of 32 is representable.

## Timing
- Reset values: `delay` = DEFAULT_TAP on all lanes, `cal_busy` = 0, `cal_done` = 0, `cal_err` = 0, FSM in IDLE.
- `cal_busy` rises the cycle after `cal_start` is accepted.
- Per-tap cost: 1 (LOAD) + SETTLE + DWELL + 1 (NEXT) cycles.
- Per-lane cost: 32 × per-tap cost + 1 (COMMIT).
- A lane's committed `delay` is visible the cycle after its COMMIT.
- `cal_done` rises in the same cycle that `cal_busy` falls.
- Reset asserted mid-sweep aborts immediately and restores all reset values. Committed delays are not retained.
- `deser_in` is sampled in the byte_clock domain only; no CDC is performed here.

## Configuration
- `CSI_RX_DLY_CAL_RESCAN_EN`:
  - Defined: a counter starts when IDLE is entered with `cal_done` = 1. After RESCAN_CYCLES idle cycles it triggers a new sweep, exactly as if `cal_start` were asserted.
  - Defined: a rescan that produces a fail keeps the lane's previously committed passing delay instead of DEFAULT_TAP, and still sets `cal_err`.
  - Not defined: calibration runs only on `cal_start`; the rescan counter and RESCAN_CYCLES are not used.

## Structure
- Package `csi_rx_cal_pkg`:
  - TAP_W = 5, NTAPS = 32.
  - FSM state enum.
  - Rotation-match function `is_rot(byte, pat)`.
- Sub-module `csi_rx_cal_eye`:
  - Inputs: tap-good strobe, tap index, clear.
  - Outputs: run/best tracker, best_start, best_len.
  - One instance, reused across lanes.

## Test plan
- Lane 0 good for taps 10..19, lane 1 good for taps 2..5, all other taps random data; pulse `cal_start`.
  - Expect `delay` lane0 = 15, lane1 = 4, `cal_err` = 0, `cal_done` = 1.
- Two good windows, taps 3..7 and 20..24 (equal length 5).
  - Expect delay = 5 (earlier window wins).
- Only taps 0..2 good (length 3 < MIN_EYE).
  - Expect delay = 3 (DEFAULT_TAP) and `cal_err[0]` = 1.
- All 32 taps good with a constant rotated byte 8'h71.
  - Expect delay = 16; a single stray byte in one tap's DWELL marks only that tap bad.
- Assert `reset_n` low midway through the lane-1 sweep.
  - Expect `delay` = 3 on all lanes, `cal_busy` = 0, `cal_done` = 0.
  - A new `cal_start` then completes normally.
  - A `cal_start` pulsed during the sweep is ignored; total sweep length is unchanged.
- With `CSI_RX_DLY_CAL_RESCAN_EN` and RESCAN_CYCLES = 100, run a passing calibration, then remove the training pattern.
  - Expect the rescan to begin 100 cycles after `cal_done`.
  - Expect the previously committed delays to be retained and `cal_err` set.
